// File: rtl/ysyx_24110015_icache_sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110015_icache_sa_pkg
// Description : Shared types and constants for the set-associative I-cache.
//               Contains the controller state encoding, the AXI burst-type
//               encodings and the AXI transfer-size code for 32-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24110015_icache_sa_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        AR     = 3'd2,
        R      = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [1:0] C_BURST_FIXED = 2'b00;
    localparam logic [1:0] C_BURST_INCR  = 2'b01;
    localparam logic [2:0] C_ARSIZE_WORD = 3'b010;

endpackage
`default_nettype wire

// File: rtl/ysyx_24110015_icache_way.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110015_icache_way
// Description : One way of the I-cache: per-set valid bit, tag and data line.
//               Reads are combinational on idx; writes happen on wr_en.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               inval         - clear every valid bit at the next edge
//               idx           - set index for read and write
//               rd_valid/tag/line - contents of the indexed set
//               wr_en, wr_tag, wr_line - allocate the indexed set
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24110015_icache_way #(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 24,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inval,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    always_ff @(posedge clk) begin
        if (rst || inval) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[idx]  <= wr_tag;
            r_data[idx] <= wr_line;
        end
    end

    assign rd_valid = r_valid[idx];
    assign rd_tag   = r_tag[idx];
    assign rd_line  = r_data[idx];

endmodule
`default_nettype wire

// File: rtl/ysyx_24110015_icache_sa.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110015_icache_sa
// Description : Set-associative instruction cache with AXI4 read master.
//               Hits answer in the LOOKUP cycle; misses refill a whole line
//               either by one INCR burst or by one single-beat AR per word.
//               Uncached requests bypass allocation. fence.i flush clears all
//               valid bits (deferred to the next IDLE cycle when busy).
// Ports       : clk, rst; req_* fetch request; flush; resp_* instruction
//               response; ar*/r* AXI read channels; hit_cnt/miss_cnt
//               saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24110015_icache_sa
    import ysyx_24110015_icache_sa_pkg::*;
#(
    parameter int BLOCK_BYTES = 16,
    parameter int SETS        = 16,
    parameter int WAYS        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_uncached,
    input  logic        req_burst,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [1:0]  arburst,
    output logic [2:0]  arsize,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF    = $clog2(BLOCK_BYTES);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = 32 - OFF - IDX;
    localparam int WORDS  = BLOCK_BYTES / 4;
    localparam int WSEL   = OFF - 2;
    localparam int LINE_W = BLOCK_BYTES * 8;
    localparam int RRW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t            r_state, w_next;
    logic [31:0]       r_addr;
    logic              r_uncached, r_burst, r_flush_pend, r_err;
    logic [WSEL-1:0]   r_beat;
    logic [LINE_W-1:0] r_line;
    logic [31:0]       r_hit_cnt, r_miss_cnt, r_resp_data;
    logic              r_resp_err;
    logic [RRW-1:0]    r_rr [SETS];

    logic [IDX-1:0]    w_idx;
    logic [TAG-1:0]    w_tag;
    logic [OFF+2:0]    w_wbit;
    logic [WAYS-1:0]   w_way_valid, w_way_hit, w_way_we;
    logic [TAG-1:0]    w_way_tag  [WAYS];
    logic [LINE_W-1:0] w_way_line [WAYS];
    logic              w_hit, w_err_now, w_fill_end, w_alloc, w_inval, w_accept;
    logic [31:0]       w_hit_word, w_fill_word;
    logic [LINE_W-1:0] w_fill_line;
    logic [RRW-1:0]    w_victim;
    logic              w_victim_valid;

    assign w_idx  = r_addr[OFF +: IDX];
    assign w_tag  = r_addr[31 -: TAG];
    assign w_wbit = {r_addr[2 +: WSEL], 5'b0_0000};

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            ysyx_24110015_icache_way #(
                .SETS  (SETS),
                .IDX_W (IDX),
                .TAG_W (TAG),
                .LINE_W(LINE_W)
            ) u_way (
                .clk     (clk),
                .rst     (rst),
                .inval   (w_inval),
                .idx     (w_idx),
                .rd_valid(w_way_valid[g]),
                .rd_tag  (w_way_tag[g]),
                .rd_line (w_way_line[g]),
                .wr_en   (w_way_we[g]),
                .wr_tag  (w_tag),
                .wr_line (w_fill_line)
            );
            assign w_way_hit[g] = w_way_valid[g] && (w_way_tag[g] == w_tag);
            assign w_way_we[g]  = w_alloc && (w_victim == RRW'(g));
        end
    endgenerate

    always_comb begin
        w_hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_way_hit[w]) begin
                w_hit_word = w_hit_word | w_way_line[w][w_wbit +: 32];
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        w_victim       = r_rr[w_idx];
        w_victim_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_way_valid[w]) begin
                w_victim       = RRW'(w);
                w_victim_valid = 1'b0;
            end
        end
    end

    // The completed line is the shift buffer with the current beat on top.
    assign w_fill_line = {rdata, r_line[LINE_W-1:32]};
    assign w_fill_word = w_fill_line[w_wbit +: 32];
    assign w_hit       = !r_uncached && (|w_way_hit);
    assign w_err_now   = r_err || (rvalid && (rresp != 2'b00));
    assign w_fill_end  = (r_state == R) && rvalid &&
                         (r_uncached ? 1'b1 :
                          r_burst    ? rlast : (r_beat == WSEL'(WORDS - 1)));
    assign w_alloc     = w_fill_end && !r_uncached && !w_err_now;
    assign w_inval     = (r_state == IDLE) && (flush || r_flush_pend);
    assign req_ready   = !rst && (r_state == IDLE) && !flush && !r_flush_pend;
    assign w_accept    = req_valid && req_ready;

    assign arsize   = C_ARSIZE_WORD;
    assign rready   = 1'b1;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        arvalid    = 1'b0;
        araddr     = '0;
        arlen      = '0;
        arburst    = C_BURST_FIXED;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (w_hit) begin
                    resp_valid = 1'b1;
                    resp_data  = w_hit_word;
                    w_next     = resp_ready ? IDLE : RESP;
                end else begin
                    w_next = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (r_uncached) begin
                    araddr = r_addr;
                end else if (r_burst) begin
                    araddr  = {r_addr[31:OFF], {OFF{1'b0}}};
                    arlen   = 8'(WORDS - 1);
                    arburst = C_BURST_INCR;
                end else begin
                    araddr = {r_addr[31:OFF], r_beat, 2'b00};
                end
                if (arready) w_next = R;
            end
            R: begin
                if (w_fill_end) begin
                    resp_valid = 1'b1;
                    resp_data  = r_uncached ? rdata : w_fill_word;
                    resp_err   = w_err_now;
                    w_next     = resp_ready ? IDLE : RESP;
                end else if (rvalid && !r_burst) begin
                    w_next = AR;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_resp_data;
                resp_err   = r_resp_err;
                if (resp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            arvalid    = 1'b0;
            resp_valid = 1'b0;
            resp_data  = '0;
            resp_err   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_uncached   <= 1'b0;
            r_burst      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_err        <= 1'b0;
            r_beat       <= '0;
            r_line       <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            // A flush seen while busy waits here until the first IDLE cycle.
            if (w_inval)    r_flush_pend <= 1'b0;
            else if (flush) r_flush_pend <= 1'b1;

            if (w_accept) begin
                r_addr     <= req_addr;
                r_uncached <= req_uncached;
                r_burst    <= req_burst;
                r_err      <= 1'b0;
            end

            if (r_state == LOOKUP) begin
                if (w_hit) begin
                    if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
                end else begin
                    r_beat <= '0;
                    if (!r_uncached && (r_miss_cnt != 32'hFFFF_FFFF))
                        r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end

            if ((r_state == R) && rvalid) begin
                r_line <= w_fill_line;
                r_err  <= w_err_now;
                r_beat <= r_beat + WSEL'(1);
            end

            if (resp_valid && !resp_ready && (r_state != RESP)) begin
                r_resp_data <= resp_data;
                r_resp_err  <= resp_err;
            end

            if (w_inval) begin
                for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
            end else if (w_alloc && w_victim_valid) begin
                r_rr[w_idx] <= (r_rr[w_idx] == RRW'(WAYS - 1)) ? '0 : r_rr[w_idx] + RRW'(1);
            end
        end
    end

endmodule
`default_nettype wire
